// File: rtl/mod_counter_sequencer.sv
// Programmable modulo-N counter sequencer: start/pause/stop control plus a bounded number of full count periods.
// Optional MOD_COUNTER_DOWN_EN adds a 'down' input, latched at start, that makes the run count down.
module mod_counter_sequencer #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
`ifdef MOD_COUNTER_DOWN_EN
    input  logic              down,
`endif
    input  logic [WIDTH-1:0]  modulus,
    input  logic [WRAP_W-1:0] wraps,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WRAP_W-1:0] wrap_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0]  MOD_MIN  = WIDTH'(2);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mod_q, mod_d;
    logic [WRAP_W-1:0]  wraps_q, wraps_d;
    logic [WRAP_W-1:0]  wrap_cnt_q, wrap_cnt_d;
    logic               err_q, err_d;
    logic               down_q, down_d;
    logic               down_in;

    logic [WIDTH-1:0]   last_val;
    logic [WIDTH-1:0]   reload_val;
    logic [WRAP_W-1:0]  wrap_inc;
    logic               at_last;

`ifdef MOD_COUNTER_DOWN_EN
    assign down_in = down;
`else
    assign down_in = 1'b0;
`endif

    // Terminal value and reload value swap roles depending on direction.
    always_comb begin
        last_val   = down_q ? '0 : (mod_q - CNT_ONE);
        reload_val = down_q ? (mod_q - CNT_ONE) : '0;
        at_last    = (count_q == last_val);
        wrap_inc   = wrap_cnt_q + WRAP_ONE;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mod_d      = mod_q;
        wraps_d    = wraps_q;
        wrap_cnt_d = wrap_cnt_q;
        down_d     = down_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start) begin
                    if (modulus >= MOD_MIN) begin
                        state_d    = S_RUN;
                        mod_d      = modulus;
                        wraps_d    = wraps;
                        down_d     = down_in;
                        wrap_cnt_d = '0;
                        count_d    = down_in ? (modulus - CNT_ONE) : '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = S_HOLD;
                end else if (at_last) begin
                    wrap_cnt_d = wrap_inc;
                    count_d    = reload_val;
                    // wraps_q == 0 means free-running: wrap_cnt just rolls over.
                    if ((wraps_q != '0) && (wrap_inc == wraps_q)) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end
                end else begin
                    count_d = down_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
                end
            end
            S_HOLD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            mod_q      <= '0;
            wraps_q    <= '0;
            wrap_cnt_q <= '0;
            err_q      <= 1'b0;
            down_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mod_q      <= mod_d;
            wraps_q    <= wraps_d;
            wrap_cnt_q <= wrap_cnt_d;
            err_q      <= err_d;
            down_q     <= down_d;
        end
    end

    assign count    = count_q;
    assign tc       = (state_q == S_RUN) && at_last;
    assign busy     = (state_q == S_RUN) || (state_q == S_HOLD);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign wrap_cnt = wrap_cnt_q;

endmodule
